// File: rtl/pi_pkg.sv
// Shared types and constants for the Leibniz-series pi sequencer.
package pi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam int unsigned PI_WIDTH_DEFAULT = 16;

    // Fixed-point 1.0 for a value with 'width' fraction bits.
    function automatic longint unsigned q_one(input int unsigned width);
        return 64'd1 << width;
    endfunction

endpackage

// File: rtl/leibniz_pi_ctrl.sv
// Sequences a fractional divider through the Leibniz series terms and
// accumulates them with alternating sign to produce pi in Q3.P_WIDTH.
module leibniz_pi_ctrl
    import pi_pkg::*;
#(
    parameter int unsigned P_WIDTH = PI_WIDTH_DEFAULT,
    parameter int unsigned P_TERMS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH+2:0] pi_out,
    output logic               div_start,
    output logic [P_WIDTH-1:0] div_numerator,
    output logic [P_WIDTH-1:0] div_denominator,
    input  logic               div_done,
    input  logic [P_WIDTH-1:0] div_decimal
);

    localparam logic [P_WIDTH+1:0] ACC_ONE = (P_WIDTH + 2)'(q_one(P_WIDTH));
    localparam logic [P_WIDTH-1:0] K_LAST  = P_WIDTH'(P_TERMS - 1);

    state_t                    state, state_nxt;
    logic signed [P_WIDTH+1:0] acc, acc_nxt;
    logic signed [P_WIDTH+1:0] term;
    logic        [P_WIDTH-1:0] k, k_nxt;

    assign div_numerator = P_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        k_nxt     = k;
        term      = $signed({2'b00, div_decimal});
        case (state)
            IDLE: begin
                // The k=0 term 1/1 is loaded directly; the divider cannot represent it.
                if (req) begin
                    acc_nxt   = ACC_ONE;
                    k_nxt     = P_WIDTH'(1);
                    state_nxt = (P_TERMS == 1) ? FINISH : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (div_done) begin
                    acc_nxt = k[0] ? (acc - term) : (acc + term);
                    if (k == K_LAST) begin
                        state_nxt = FINISH;
                    end else begin
                        k_nxt     = k + 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != IDLE);
        div_start       = (state == ISSUE);
        div_denominator = '0;
        if (state == ISSUE || state == WAIT) begin
            div_denominator = {k[P_WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            k      <= '0;
            done   <= 1'b0;
            pi_out <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            k     <= k_nxt;
            done  <= (state == FINISH);
            // acc is never negative, so its low bits hold the whole magnitude.
            if (state == FINISH) begin
                pi_out <= {acc[P_WIDTH:0], 2'b00};
            end
        end
    end

endmodule

// File: doc/leibniz_pi_ctrl.md
# leibniz_pi_ctrl

Sequencer that computes π by the Leibniz series π = 4·Σ(−1)^k/(2k+1), k = 0..P_TERMS−1. It drives the fixed-point fractional divider `calc_decimal` with numerator 1 and denominator 2k+1, then consumes each quotient fraction. It accumulates the terms with alternating sign and reports the scaled result. It sits directly upstream and downstream of `calc_decimal` at the pi top level.

## Interface
Parameters:
- P_WIDTH, 16, fraction bits of the divider result and the accumulator.
- P_TERMS, 1024, number of series terms including k=0. Legal range is 1..32768, so that 2k+1 fits in P_WIDTH = 16 bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  start a run. Sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted req until done.
- done  out  1  one-cycle pulse when pi_out is updated.
- pi_out  out  P_WIDTH+3  result, unsigned Q3.P_WIDTH. Holds its value until the next done.
- div_start  out  1  one-cycle start pulse to the divider.
- div_numerator  out  P_WIDTH  constant 1.
- div_denominator  out  P_WIDTH  2k+1. Stable from div_start until div_done.
- div_done  in  1  divider completion pulse.
- div_decimal  in  P_WIDTH  quotient fraction, floor(2^P_WIDTH/(2k+1)). Valid when div_done=1.

## Operation
- The accumulator `acc` is signed, P_WIDTH+2 bits, in Q1.P_WIDTH format. The term counter `k` is P_WIDTH bits.
- The k=0 term (1/1) bypasses the divider because its quotient 2^P_WIDTH would truncate to 0. Instead, `acc` is initialised to 1<<P_WIDTH.
- States:
  - IDLE → on req: set acc=1<<P_WIDTH and k=1. Go to FINISH if P_TERMS==1, otherwise go to ISSUE.
  - ISSUE: assert div_start=1 for exactly this cycle, with div_denominator=2k+1. Go to WAIT.
  - WAIT: hold the operands. When div_done=1:
    - if k is odd, acc −= div_decimal; if k is even, acc += div_decimal.
    - Then, if k==P_TERMS−1, go to FINISH; otherwise k++ and go to ISSUE.
  - FINISH: pi_out = acc<<2 (zero-extended into P_WIDTH+3 bits), done=1. Go to IDLE.
- The acc range stays within [2/3, 1.0] after any prefix, so no overflow occurs.
- Boundary rules:
  - req while busy is ignored.
  - div_done outside WAIT is ignored; acc and k are unchanged.
  - req and div_done together in IDLE: the req is accepted and the div_done is ignored.
  - Reset mid-run (asserted at any state) applies asynchronously: state=IDLE, and all outputs go to their reset values. The next req starts a clean run.
- Reset values: busy=0, done=0, div_start=0, div_denominator=0, pi_out=0, acc=0, k=0. div_numerator is a constant 1.

## Timing
- L is the divider latency: the number of cycles from the div_start cycle to the div_done cycle, L ≥ 1.
- The req cycle enters ISSUE (or FINISH) on the next edge.
- Each divided term costs 1+L cycles.
- done asserts 1 + (P_TERMS−1)·(1+L) + 1 cycles after the req cycle. For P_TERMS=1 this is 2 cycles.
- busy is high in ISSUE, WAIT and FINISH, and low in IDLE.
- pi_out changes only on the same edge that asserts done.
- Exactly P_TERMS−1 div_start pulses occur per run.

## Structure
- Package `pi_pkg` holds:
  - the `state_t` enum (IDLE, ISSUE, WAIT, FINISH);
  - a localparam for the default P_WIDTH;
  - a function returning the Q-format constant 1<<P_WIDTH.
- No sub-module. The divider (`calc_decimal`) is instantiated beside this block in the pi top level and wired through the div_* ports.

## Test plan
All scenarios use a behavioural divider model with L=3 returning floor(65536/den), P_WIDTH=16.
- P_TERMS=1: req → done 2 cycles later, pi_out=0x40000 (4.0), zero div_start pulses.
- P_TERMS=2: den=3 returns 21845; acc=43691; pi_out=174764 (0x2AAAC). done at cycle 6.
- P_TERMS=3: second term den=5 returns 13107; acc=56798; pi_out=227192 (0x37778). Exactly 2 div_start pulses; div_denominator stable throughout each WAIT.
- req pulsed during WAIT, and div_done pulsed in IDLE: no extra run, pi_out and busy unaffected.
- rst asserted mid-WAIT of a P_TERMS=3 run: busy, div_start and pi_out read 0 before the next clock edge. A fresh req then produces 0x37778.
- P_TERMS=1024 against a golden floor-arithmetic model: pi_out matches bit-exactly, about 3.1406 (0x3240C region), with busy high continuously for the run.
